// File: rtl/menu_screen_if.sv
// Pixel, button and selection signals between the menu renderer,
// the text renderer, the button debouncers and the OLED mux.
interface menu_screen_if;
  logic [12:0] pixel_index;
  logic        frame_tick;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic        char_pixel;
  logic        text_active;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] pixel_data;
  logic [2:0]  sel_idx;
  logic        sel_valid;
  logic        busy;

  modport slave (
    input  pixel_index, frame_tick,
    input  btn_up, btn_down, btn_sel,
    input  char_pixel, text_active,
    output x, y, pixel_data,
    output sel_idx, sel_valid, busy
  );

  modport master (
    output pixel_index, frame_tick,
    output btn_up, btn_down, btn_sel,
    output char_pixel, text_active,
    input  x, y, pixel_data,
    input  sel_idx, sel_valid, busy
  );
endinterface

// File: rtl/menu_screen.sv
// Stacked menu boxes on the 96x64 RGB565 OLED with an up/down/select
// highlight state machine; pixel_data lags pixel_index by one clock.
module menu_screen #(
  parameter int NUM_ITEMS      = 4,
  parameter int Y_TOP          = 2,
  parameter int ITEM_H         = 14,
  parameter int GAP            = 2,
  parameter int X_L            = 3,
  parameter int X_R            = 92,
  parameter int BLINK_FRAMES   = 15,
  parameter int CONFIRM_FRAMES = 30
) (
  input  logic    clk,
  input  logic    rst_n,
  menu_screen_if.slave bus
);
  localparam logic [0:0] BROWSE  = 1'b0;
  localparam logic [0:0] CONFIRM = 1'b1;

  localparam int PITCH    = ITEM_H + GAP;
  localparam int LAST_BOT = Y_TOP + (NUM_ITEMS - 1) * PITCH + ITEM_H - 1;

  localparam logic [2:0]  LAST_IDX   = 3'(NUM_ITEMS - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0] CONF_LAST  = 16'(CONFIRM_FRAMES - 1);

  logic [0:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic        blink_on_q, blink_on_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic [15:0] conf_cnt_q, conf_cnt_d;
  logic        valid_q, valid_d;
  logic [15:0] pix_q, pix_d;
  logic        up_arm_q, dn_arm_q, sl_arm_q;

  logic [31:0] px, py;
  logic        hit, on_edge, sel_hit, txt;
  logic [2:0]  hit_idx;
  logic        ev_up, ev_dn, ev_sl;

  assign bus.x = 7'(bus.pixel_index % 13'd96);
  assign bus.y = 6'(bus.pixel_index / 13'd96);
  assign px    = 32'(bus.x);
  assign py    = 32'(bus.y);

  always_comb begin
    hit     = 1'b0;
    on_edge = 1'b0;
    hit_idx = 3'd0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (py >= 32'(Y_TOP + i * PITCH) &&
          py <= 32'(Y_TOP + i * PITCH + ITEM_H - 1) &&
          px >= 32'(X_L) && px <= 32'(X_R)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
        on_edge = (py == 32'(Y_TOP + i * PITCH)) ||
                  (py == 32'(Y_TOP + i * PITCH + ITEM_H - 1)) ||
                  (px == 32'(X_L)) || (px == 32'(X_R));
      end
    end
  end

  function automatic logic [15:0] fill_color(input logic [2:0] idx);
    logic [15:0] c;
    c = 16'h0000;
    unique case (1'b1)
      (idx == 3'd0): c = 16'hE9E6;
      (idx == 3'd1): c = 16'h55C9;
      (idx == 3'd2): c = 16'h1A73;
      default:       c = 16'h0000;
    endcase
    return c;
  endfunction

  assign sel_hit = hit && (hit_idx == sel_q);
  assign txt     = bus.text_active & bus.char_pixel;

  // Selected fill inverts during CONFIRM so the chosen item stands out
  always_comb begin
    pix_d = 16'h0000;
    if (hit && on_edge) begin
      if (sel_hit && (state_q == CONFIRM || blink_on_q))
        pix_d = 16'hFFE0;
      else
        pix_d = 16'hFFFF;
    end else if (sel_hit && state_q == CONFIRM) begin
      pix_d = txt ? 16'h0000 : 16'hFFFF;
    end else if (txt) begin
      pix_d = 16'hFFFF;
    end else if (hit) begin
      pix_d = fill_color(hit_idx);
    end
  end

  // Arm flags clear on reset so a button held through reset is ignored
  assign ev_up = bus.btn_up   & up_arm_q;
  assign ev_dn = bus.btn_down & dn_arm_q;
  assign ev_sl = bus.btn_sel  & sl_arm_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    conf_cnt_d  = conf_cnt_q;
    valid_d     = 1'b0;
    case (state_q)
      BROWSE: begin
        if (ev_sl) begin
          state_d    = CONFIRM;
          conf_cnt_d = 16'd0;
        end else if (ev_up && !ev_dn) begin
          sel_d = (sel_q == 3'd0) ? LAST_IDX : sel_q - 3'd1;
        end else if (ev_dn && !ev_up) begin
          sel_d = (sel_q == LAST_IDX) ? 3'd0 : sel_q + 3'd1;
        end
        if (bus.frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = 16'd0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        if (bus.frame_tick) begin
          if (conf_cnt_q == CONF_LAST) begin
            state_d     = BROWSE;
            valid_d     = 1'b1;
            blink_on_d  = 1'b1;
            blink_cnt_d = 16'd0;
          end else begin
            conf_cnt_d = conf_cnt_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BROWSE;
      sel_q       <= 3'd0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= 16'd0;
      conf_cnt_q  <= 16'd0;
      valid_q     <= 1'b0;
      pix_q       <= 16'h0000;
      up_arm_q    <= 1'b0;
      dn_arm_q    <= 1'b0;
      sl_arm_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      conf_cnt_q  <= conf_cnt_d;
      valid_q     <= valid_d;
      pix_q       <= pix_d;
      up_arm_q    <= ~bus.btn_up;
      dn_arm_q    <= ~bus.btn_down;
      sl_arm_q    <= ~bus.btn_sel;
    end
  end

  assign bus.pixel_data = pix_q;
  assign bus.sel_idx    = sel_q;
  assign bus.sel_valid  = valid_q;
  assign bus.busy       = (state_q == CONFIRM);

  always @(posedge clk)
    assert (LAST_BOT <= 63 && NUM_ITEMS >= 2 && NUM_ITEMS <= 8);
endmodule

// File: tb/tb_menu_screen.sv
// Directed and randomized checks of menu_screen against a
// geometry/selection reference model.
module tb_menu_screen;
  localparam int N  = 4;
  localparam int YT = 2;
  localparam int IH = 14;
  localparam int GP = 2;
  localparam int XL = 3;
  localparam int XR = 92;
  localparam int BF = 15;
  localparam int CF = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  menu_screen_if bus();

  menu_screen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_sel;
  bit          m_conf;
  int          m_bticks;
  int          m_cticks;
  bit          m_up_arm, m_dn_arm, m_sl_arm;
  logic [15:0] exp_pix;
  bit          exp_valid;

  function automatic logic [15:0] ref_pixel(int idx, bit ta, bit cp);
    int x, y, r, b, o;
    bit inbox, border, txt, blink;
    logic [15:0] fill;
    x = idx % 96;
    y = idx / 96;
    b = 0;
    inbox = 0;
    border = 0;
    txt = ta && cp;
    blink = ((m_bticks / BF) % 2) == 0;
    if (y >= YT) begin
      r = y - YT;
      b = r / (IH + GP);
      o = r % (IH + GP);
      inbox = (b < N) && (o < IH) && (x >= XL) && (x <= XR);
      border = (o == 0) || (o == IH - 1) || (x == XL) || (x == XR);
    end
    case (b)
      0: fill = 16'hE9E6;
      1: fill = 16'h55C9;
      2: fill = 16'h1A73;
      default: fill = 16'h0000;
    endcase
    if (inbox && border)
      return (b == m_sel && (m_conf || blink)) ? 16'hFFE0 : 16'hFFFF;
    if (inbox && b == m_sel && m_conf)
      return txt ? 16'h0000 : 16'hFFFF;
    if (txt)
      return 16'hFFFF;
    if (inbox)
      return fill;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_sel = 0;
    m_conf = 0;
    m_bticks = 0;
    m_cticks = 0;
    m_up_arm = 0;
    m_dn_arm = 0;
    m_sl_arm = 0;
    exp_valid = 0;
    exp_pix = 16'h0000;
  endtask

  task automatic step(bit up, bit dn, bit sl, bit tk);
    bit eu, ed, es;
    bus.btn_up = up;
    bus.btn_down = dn;
    bus.btn_sel = sl;
    bus.frame_tick = tk;
    @(posedge clk);
    exp_pix = ref_pixel(int'(bus.pixel_index), bus.text_active,
                        bus.char_pixel);
    eu = up && m_up_arm;
    ed = dn && m_dn_arm;
    es = sl && m_sl_arm;
    m_up_arm = !up;
    m_dn_arm = !dn;
    m_sl_arm = !sl;
    exp_valid = 0;
    if (!m_conf) begin
      if (es) begin
        m_conf = 1;
        m_cticks = 0;
      end else if (eu && !ed) begin
        m_sel = (m_sel + N - 1) % N;
      end else if (ed && !eu) begin
        m_sel = (m_sel + 1) % N;
      end
      if (tk) m_bticks++;
    end else if (tk) begin
      m_cticks++;
      if (m_cticks == CF) begin
        m_conf = 0;
        m_bticks = 0;
        exp_valid = 1;
      end
    end
    #1;
  endtask

  task automatic set_pix(int idx, bit ta, bit cp);
    bus.pixel_index = 13'(idx);
    bus.text_active = ta;
    bus.char_pixel = cp;
  endtask

  task automatic do_reset();
    bus.btn_up = 0;
    bus.btn_down = 0;
    bus.btn_sel = 0;
    bus.frame_tick = 0;
    set_pix(0, 0, 0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.btn_up = 0;
    bus.btn_down = 1;
    bus.btn_sel = 0;
    bus.frame_tick = 0;
    set_pix(96 * 2 + 3, 0, 0);
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.pixel_data !== 16'h0000 || bus.sel_idx !== 3'd0 ||
        bus.busy !== 1'b0 || bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals pix=%h sel=%0d busy=%b valid=%b want 0000/0/0/0",
               bus.pixel_data, bus.sel_idx, bus.busy, bus.sel_valid);
    end
    rst_n = 1;
    model_reset();
    repeat (3) step(0, 1, 0, 0);
    n_tests++;
    if (bus.sel_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_held_btn sel=%0d want 0", bus.sel_idx);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    n_tests++;
    if (bus.sel_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_rearm sel=%0d want 1", bus.sel_idx);
    end
  endtask

  task automatic test_render();
    int idx[5];
    bit ta[5];
    logic [15:0] want[5];
    idx = '{96 * 2 + 3, 96 * 5 + 10, 96 * 20 + 3, 96 * 16 + 10, 96 * 40 + 50};
    ta = '{0, 0, 0, 0, 1};
    want = '{16'hFFE0, 16'hE9E6, 16'hFFFF, 16'h0000, 16'hFFFF};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_pix(idx[i], ta[i], ta[i]);
      step(0, 0, 0, 0);
      n_tests++;
      if (bus.pixel_data !== want[i]) begin
        n_fail++;
        $display("FAIL render_%0d got %h want %h", i, bus.pixel_data, want[i]);
      end
    end
    set_pix(96 * 40 + 50, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.pixel_data !== 16'h1A73) begin
      n_fail++;
      $display("FAIL render_fill2 got %h want 1a73", bus.pixel_data);
    end
  endtask

  task automatic test_navigation();
    do_reset();
    repeat (3) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    n_tests++;
    if (bus.sel_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL nav_down3 got %0d want 3", bus.sel_idx);
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.sel_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL nav_wrap_down got %0d want 0", bus.sel_idx);
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.sel_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL nav_wrap_up got %0d want 3", bus.sel_idx);
    end
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.sel_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL nav_up_down got %0d want 3", bus.sel_idx);
    end
  endtask

  task automatic test_blink();
    do_reset();
    set_pix(96 * 2 + 3, 0, 0);
    repeat (14) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.pixel_data !== 16'hFFE0) begin
      n_fail++;
      $display("FAIL blink_14 got %h want ffe0", bus.pixel_data);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.pixel_data !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL blink_off got %h want ffff", bus.pixel_data);
    end
    repeat (15) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.pixel_data !== 16'hFFE0) begin
      n_fail++;
      $display("FAIL blink_on got %h want ffe0", bus.pixel_data);
    end
  endtask

  task automatic test_confirm();
    do_reset();
    repeat (2) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.sel_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL conf_enter busy=%b sel=%0d want 1/2", bus.busy, bus.sel_idx);
    end
    set_pix(96 * 36 + 10, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.pixel_data !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL conf_fill got %h want ffff", bus.pixel_data);
    end
    set_pix(96 * 36 + 10, 1, 1);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.pixel_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL conf_text got %h want 0000", bus.pixel_data);
    end
    set_pix(96 * 34 + 3, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.sel_idx !== 3'd2 || bus.pixel_data !== 16'hFFE0) begin
      n_fail++;
      $display("FAIL conf_frozen sel=%0d pix=%h want 2/ffe0",
               bus.sel_idx, bus.pixel_data);
    end
    repeat (29) step(0, 0, 0, 1);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL conf_29 busy=%b valid=%b want 1/0", bus.busy, bus.sel_valid);
    end
    step(0, 0, 0, 1);
    n_tests++;
    if (bus.sel_valid !== 1'b1 || bus.sel_idx !== 3'd2 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL conf_done valid=%b sel=%0d busy=%b want 1/2/0",
               bus.sel_valid, bus.sel_idx, bus.busy);
    end
    step(0, 0, 0, 0);
    n_tests++;
    if (bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL conf_pulse valid=%b want 0", bus.sel_valid);
    end
  endtask

  task automatic test_sel_priority();
    do_reset();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.sel_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL sel_prio busy=%b sel=%0d want 1/1", bus.busy, bus.sel_idx);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_reset();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1);
    #2 rst_n = 0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.sel_idx !== 3'd0 || bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_vals busy=%b sel=%0d valid=%b want 0/0/0",
               bus.busy, bus.sel_idx, bus.sel_valid);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    seen = 0;
    repeat (40) begin
      step(0, 0, 0, 1);
      if (bus.sel_valid === 1'b1) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_valid saw sel_valid=1 want none");
    end
  endtask

  task automatic test_random();
    bit up, dn, sl;
    do_reset();
    up = 0;
    dn = 0;
    sl = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) up = ~up;
      if ($urandom_range(0, 5) == 0) dn = ~dn;
      if ($urandom_range(0, 11) == 0) sl = ~sl;
      set_pix(int'($urandom_range(0, 6143)), 1'($urandom), 1'($urandom));
      step(up, dn, sl, $urandom_range(0, 3) == 0);
      n_tests++;
      if (bus.pixel_data !== exp_pix || bus.sel_idx !== 3'(m_sel) ||
          bus.busy !== m_conf || bus.sel_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rand_%0d pix=%h sel=%0d busy=%b valid=%b want %h/%0d/%b/%b",
                 c, bus.pixel_data, bus.sel_idx, bus.busy, bus.sel_valid,
                 exp_pix, m_sel, m_conf, exp_valid);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_render();
    test_navigation();
    test_blink();
    test_confirm();
    test_sel_priority();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/menu_screen.md
Name: menu_screen

Overview:
- Parametrised successor of the static home-screen renderer for the 96x64 RGB565 OLED.
- Draws NUM_ITEMS stacked, bordered menu boxes and owns a selection state machine: the up/down buttons move the highlight and the select button confirms an item.
- Sits between the debounced button inputs and the OLED pixel mux.
- Text glyphs come from the existing text renderer through the x/y and char_pixel/text_active ports.

Parameters:
- NUM_ITEMS, 4, number of menu boxes (2..8).
- Y_TOP, 2, top row of box 0.
- ITEM_H, 14, height of each box in rows, borders included.
- GAP, 2, blank rows between boxes.
- X_L, 3, left border column.
- X_R, 92, right border column.
- BLINK_FRAMES, 15, frame ticks per highlight blink half-period.
- CONFIRM_FRAMES, 30, frame ticks spent in CONFIRM.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- pixel_index, in, 13, OLED pixel index, 0..6143.
- frame_tick, in, 1, one-cycle pulse per OLED frame.
- btn_up, in, 1, debounced level.
- btn_down, in, 1, debounced level.
- btn_sel, in, 1, debounced level.
- char_pixel, in, 1, glyph pixel returned by the text renderer.
- text_active, in, 1, text region flag returned by the text renderer.
- x, out, 7, pixel_index % 96 (combinational), to the text renderer.
- y, out, 6, pixel_index / 96 (combinational), to the text renderer.
- pixel_data, out, 16, registered RGB565 pixel.
- sel_idx, out, 3, currently highlighted item.
- sel_valid, out, 1, one-cycle pulse when a confirm completes.
- busy, out, 1, high while in CONFIRM.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pixel_data = 0, sel_idx = 0, sel_valid = 0, busy = 0.
  - State = BROWSE, blink_on = 1, blink and confirm counters = 0.
  - Button edge registers = 0, so a button held through reset produces no event.
- Buttons: each input has a rising-edge detector, one register per button. An event is input=1 with the previous sample = 0.
- Geometry:
  - Box i spans rows Y_TOP+i*(ITEM_H+GAP) to that value + ITEM_H - 1, and columns X_L..X_R.
  - Border = first/last row or column of the box; fill = the rest of the box.
  - All arithmetic is unsigned with no overflow at the defaults. Parameters that push a box past row 63 are illegal; use a simulation assertion.
- Colours:
  - Fill by index: 0 = E9E6, 1 = 55C9, 2 = 1A73, 3 and above = 0000.
  - Normal border = FFFF. Highlight border = FFE0.
  - Background = 0000. Text = FFFF where text_active & char_pixel.
- Pixel pipeline: pixel_data is registered, one clk latency from pixel_index.
  - Selected box border, BROWSE, blink_on=1 -> FFE0.
  - Selected box border, BROWSE, blink_on=0 -> FFFF.
  - Selected box border, CONFIRM -> FFE0 steady.
  - Selected box fill in CONFIRM -> FFFF, with text pixels 0000 (inverted).
  - Every other pixel uses the normal colour scheme.
- FSM states:
  - BROWSE:
    - up event -> sel_idx-1, wrapping 0 -> NUM_ITEMS-1.
    - down event -> sel_idx+1, wrapping NUM_ITEMS-1 -> 0.
    - up and down in the same cycle -> no change.
    - sel event -> CONFIRM, and the confirm counter clears. sel has priority over up/down in the same cycle; sel_idx is unchanged.
    - frame_tick advances the blink counter; at BLINK_FRAMES-1 the counter wraps to 0 and blink_on toggles.
  - CONFIRM:
    - busy = 1. All button events are ignored and sel_idx is frozen.
    - frame_tick increments the confirm counter. The tick that reaches CONFIRM_FRAMES-1 moves to BROWSE and asserts sel_valid for exactly one cycle, with sel_idx valid.
    - On return: blink_on = 1 and the blink counter clears.
- Reset mid-CONFIRM: immediate return to reset values, with no sel_valid.
- A frame_tick and a button event in the same cycle are both processed.

Test Plan:
- Reset: hold rst_n=0 with btn_down=1, then release -> sel_idx=0, no movement until btn_down falls and rises again; pixel_data=0000 at reset.
- Render: pixel_index=96*2+3 (box 0 top-left) -> FFE0 one cycle later. Then index 96*5+10 with text_active=0 -> E9E6. Then 96*20+3 (box 1 border) -> FFFF. Then 96*16+10 (gap) -> 0000.
- Navigation: 3 down pulses -> sel_idx=3. Fourth down -> 0. Up from 0 -> 3. Up and down rising in the same cycle -> sel_idx unchanged.
- Blink: 15 frame_ticks in BROWSE -> box-0 border pixel reads FFFF. 15 more -> FFE0.
- Confirm:
  - sel at sel_idx=2 -> busy=1; box-2 fill pixel reads FFFF; up/down ignored.
  - After 30 frame_ticks: one-cycle sel_valid with sel_idx=2, and busy=0.
  - sel and down in the same cycle -> CONFIRM, sel_idx unchanged.
- Reset abort: assert rst_n low after 10 frame_ticks in CONFIRM -> busy=0, sel_idx=0, and sel_valid never pulses.
